// File: rtl/synth_param_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : synth_pkg
// Brief    : Shared types and constants for the synth parameter loader.
// Revision : 1.0  initial release
// ============================================================================
package synth_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int PARAM_W     = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        COMMIT  = 3'd3,
        WAIT_CS = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/synth_param_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : synth_param_loader_if
// Brief    : 3-wire serial link plus committed-write report of the loader.
// Revision : 1.0  initial release
// ============================================================================
interface synth_param_loader_if
    import synth_pkg::*;
#(
    parameter int ADDR_W = 4
);
    logic                 sclk;
    logic                 sdata;
    logic                 cs_n;
    logic                 wr_strobe;
    logic [ADDR_W-1:0]    wr_addr;
    logic [PARAM_W-1:0]   wr_data;

    modport master (
        output sclk, sdata, cs_n,
        input  wr_strobe, wr_addr, wr_data
    );

    modport slave (
        input  sclk, sdata, cs_n,
        output wr_strobe, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/synth_param_loader_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Multi-flop synchronizer with rise/fall detection on the synced level.
// Revision : 1.0  initial release
// ============================================================================
module sync_edge
    import synth_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_din};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_level = r_chain[SYNC_STAGES-1];
    assign o_rise  = r_chain[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_chain[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/synth_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : synth_param_loader
// Brief    : Serial (addr,data) frame receiver committing into a parameter bank.
// Revision : 1.0  initial release
// ============================================================================
module synth_param_loader
    import synth_pkg::*;
#(
    parameter int NUM_PARAMS = 16,
    parameter int ADDR_W     = 4
)(
    input  logic                            clk,
    input  logic                            reset_n,
    synth_param_loader_if.slave             link,
    output logic [NUM_PARAMS*PARAM_W-1:0]   params,
    output logic                            frame_err,
    output logic                            busy
);

    localparam logic [PARAM_W:0] c_num_params = (PARAM_W+1)'(NUM_PARAMS);

    // Bit order of the sync vectors: 0 = sclk, 1 = sdata, 2 = cs_n
    logic [2:0] w_pins;
    logic [2:0] w_level;
    logic [2:0] w_rise;
    logic [2:0] w_fall;

    assign w_pins = {link.cs_n, link.sdata, link.sclk};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        sync_edge u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .i_din   (w_pins[i]),
            .o_level (w_level[i]),
            .o_rise  (w_rise[i]),
            .o_fall  (w_fall[i])
        );
    end

    logic w_sclk_rise, w_sdata, w_cs_rise, w_cs_fall, w_cs_level;
    logic w_unused;
    assign w_sclk_rise = w_rise[0];
    assign w_sdata     = w_level[1];
    assign w_cs_rise   = w_rise[2];
    assign w_cs_fall   = w_fall[2];
    assign w_cs_level  = w_level[2];
    assign w_unused    = ^{w_level[0], w_fall[1:0], w_rise[1]};

    loader_state_t        r_state;
    logic [2:0]           r_bitcnt;
    logic [PARAM_W-1:0]   r_shift;
    logic [PARAM_W-1:0]   r_addr;
    logic                 r_strobe;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [PARAM_W-1:0]   r_wr_data;
    logic                 r_err;

    logic [PARAM_W-1:0]   w_shift_next;
    logic                 w_last_bit;
    logic                 w_addr_ok;

    always_comb begin
        w_shift_next           = r_shift;
        w_shift_next[r_bitcnt] = w_sdata;
    end

    assign w_last_bit = w_sclk_rise && (r_bitcnt == 3'd7);
    // Full 8-bit compare: any nonzero upper address bit is out of range
    assign w_addr_ok  = {1'b0, r_addr} < c_num_params;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bitcnt  <= 3'd0;
            r_shift   <= '0;
            r_addr    <= '0;
            r_strobe  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_sclk_rise && (r_state == ADDR || r_state == DATA)) begin
                r_shift  <= w_shift_next;
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_state  <= ADDR;
                        r_bitcnt <= 3'd0;
                        r_shift  <= '0;
                        r_err    <= 1'b0;
                    end
                end
                ADDR: begin
                    if (w_cs_rise) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_last_bit) begin
                        r_addr  <= w_shift_next;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    // A 16th bit landing with the cs_n rise still completes the frame
                    if (w_last_bit) begin
                        if (w_addr_ok) begin
                            r_state  <= COMMIT;
                            r_strobe <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= w_cs_rise ? IDLE : WAIT_CS;
                        end
                    end else if (w_cs_rise) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                COMMIT: begin
                    r_wr_addr <= r_addr[ADDR_W-1:0];
                    r_wr_data <= r_shift;
                    r_state   <= w_cs_level ? IDLE : WAIT_CS;
                end
                WAIT_CS: begin
                    if (w_cs_rise) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [PARAM_W-1:0] r_bank [NUM_PARAMS];

    for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_bank
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_bank[i] <= '0;
            end else if (r_state == COMMIT && r_addr == PARAM_W'(i)) begin
                r_bank[i] <= r_shift;
            end
        end
        assign params[PARAM_W*i +: PARAM_W] = r_bank[i];
    end

    assign link.wr_strobe = r_strobe;
    assign link.wr_addr   = r_wr_addr;
    assign link.wr_data   = r_wr_data;
    assign frame_err      = r_err;
    assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_synth_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_synth_param_loader
// Brief    : Directed frames against a frame-level model of the parameter bank.
// Revision : 1.0  initial release
// ============================================================================
module tb_synth_param_loader;

    localparam int NP = 16;

    logic            clk;
    logic            reset_n;
    logic [NP*8-1:0] params;
    logic            frame_err;
    logic            busy;

    synth_param_loader_if #(.ADDR_W(4)) u_if ();

    synth_param_loader #(.NUM_PARAMS(NP), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .link      (u_if),
        .params    (params),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: bank contents and the queue of writes a frame must produce
    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_q[$];
    logic [7:0] model_bank [NP];
    bit         pend;
    wr_t        pend_wr;

    function automatic logic [NP*8-1:0] pack_bank();
        logic [NP*8-1:0] v;
        for (int i = 0; i < NP; i++) v[8*i +: 8] = model_bank[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NP; i++) model_bank[i] = 8'h00;
            exp_q.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                model_bank[pend_wr.a[3:0]] = pend_wr.d;
                check("wr_addr", 128'(u_if.wr_addr), 128'(pend_wr.a));
                check("wr_data", 128'(u_if.wr_data), 128'(pend_wr.d));
                pend = 1'b0;
            end
            if (u_if.wr_strobe) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 128'd1, 128'd0);
                end else begin
                    pend_wr = exp_q.pop_front();
                    pend    = 1'b1;
                end
            end
            check("params", 128'(params), 128'(pack_bank()));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit raise_cs);
        u_if.sdata = b;
        wait_clk(4);
        u_if.sclk = 1'b1;
        if (raise_cs) u_if.cs_n = 1'b1;
        wait_clk(4);
        u_if.sclk = 1'b0;
    endtask

    // A frame commits exactly when all 16 bits arrive and the address is in range
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] d,
                         input int nbits, input bit simul);
        logic [19:0] w;
        bit          commits;
        w       = {4'b1011, d, a};
        commits = (nbits >= 16) && (a < 8'(NP));
        if (commits) exp_q.push_back('{a: a, d: d});
        u_if.cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) send_bit(w[i], simul && (i == nbits - 1));
        if (!simul) begin
            wait_clk(4);
            u_if.cs_n = 1'b1;
        end
        wait_clk(8);
        check({tag, "_err"},     128'(frame_err), 128'(!commits));
        check({tag, "_busy"},    128'(busy), 128'd0);
        check({tag, "_missing"}, 128'(exp_q.size()), 128'd0);
    endtask

    logic [127:0] lit;

    initial begin
        reset_n    = 1'b0;
        u_if.sclk  = 1'b0;
        u_if.sdata = 1'b0;
        u_if.cs_n  = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(3);
        check("rst_params", 128'(params), 128'd0);
        check("rst_err",    128'(frame_err), 128'd0);
        check("rst_busy",   128'(busy), 128'd0);
        check("rst_strobe", 128'(u_if.wr_strobe), 128'd0);
        check("rst_waddr",  128'(u_if.wr_addr), 128'd0);
        check("rst_wdata",  128'(u_if.wr_data), 128'd0);

        frame("t1", 8'h03, 8'hA5, 16, 1'b0);
        lit = '0; lit[31:24] = 8'hA5;
        check("t1_params_lit", 128'(params), lit);
        check("t1_waddr_lit",  128'(u_if.wr_addr), 128'd3);
        check("t1_wdata_lit",  128'(u_if.wr_data), 128'hA5);

        frame("t2", 8'h10, 8'hFF, 16, 1'b0);
        check("t2_params_lit", 128'(params), lit);

        // frame_err from t2 must clear on the next cs_n fall
        u_if.cs_n = 1'b0;
        wait_clk(4);
        check("t3_err_cleared", 128'(frame_err), 128'd0);
        check("t3_busy_start",  128'(busy), 128'd1);
        u_if.cs_n = 1'b1;
        wait_clk(8);
        frame("t3_abort", 8'h00, 8'h7E, 11, 1'b0);
        frame("t3_valid", 8'h00, 8'h7E, 16, 1'b0);
        check("t3_p0_lit", 128'(params[7:0]), 128'h7E);

        frame("t4", 8'h01, 8'h3C, 20, 1'b0);
        lit[7:0] = 8'h7E; lit[15:8] = 8'h3C;
        check("t4_params_lit", 128'(params), lit);

        // t5: reset mid-frame, then sclk with cs_n still low must be ignored
        u_if.cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 12; i++) send_bit(i[0], 1'b0);
        check("t5_busy_mid", 128'(busy), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_params", 128'(params), 128'd0);
        check("t5_async_busy",   128'(busy), 128'd0);
        check("t5_async_waddr",  128'(u_if.wr_addr), 128'd0);
        check("t5_async_wdata",  128'(u_if.wr_data), 128'd0);
        wait_clk(3);
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
        wait_clk(4);
        check("t5_idle_busy",   128'(busy), 128'd0);
        check("t5_idle_params", 128'(params), 128'd0);
        u_if.cs_n = 1'b1;
        wait_clk(8);

        frame("t6", 8'h0F, 8'h81, 16, 1'b1);
        lit = '0; lit[127:120] = 8'h81;
        check("t6_params_lit", 128'(params), lit);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
